// File: rtl/check4_detector.sv
// Streaming check-4 corner pre-filter: compares the N/S/E/W pixels at radius 3
// against the centre +/- THRESHOLD and marks corner candidates white (8'hFF).
module check4_detector #(
  parameter int WIDTH     = 800,
  parameter int HEIGHT    = 600,
  parameter int THRESHOLD = 20
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] din,
  input  logic       valid,
  output logic [7:0] dout,
  output logic       validout
);

  localparam int CW    = $clog2(WIDTH);
  localparam int RW    = $clog2(HEIGHT);
  localparam int PRIME = 3 * WIDTH;
  localparam int BW    = $clog2(PRIME + 1);

  localparam logic [CW-1:0] LAST_COL = CW'(WIDTH - 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(HEIGHT - 1);
  localparam logic [BW-1:0] PRIME_B  = BW'(PRIME);
  localparam logic [8:0]    THR      = 9'(THRESHOLD);

  // Position of the newest input pixel; the centre shares its column and
  // sits three rows above it.
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [7:0]    dout_q, dout_d;
  logic          validout_q, validout_d;

  // line_q[i][a] holds the pixel seen (i+1) lines ago at column a.
  logic [7:0] line_q [6][WIDTH];
  // Centre-row taps: tap_q[2] is the centre, tap_q[5] the W neighbour;
  // the newest tap (E neighbour) is read straight from the line store.
  logic [7:0] tap_q [6];
  logic [7:0] tap_d [6];

  logic [CW:0]   col_p3_wide;
  logic [CW-1:0] col_p3;
  logic [RW-1:0] c_row;
  logic [7:0]    px_c, px_n, px_s, px_e, px_w;
  logic [7:0]    nb [4];
  logic [2:0]    n_bright, n_dark;
  logic          border, corner, primed;

  always_comb begin
    col_d  = col_q;
    row_d  = row_q;
    beat_d = beat_q;
    primed = (beat_q == PRIME_B);
    if (valid) begin
      if (col_q == LAST_COL) begin
        col_d = '0;
        row_d = (row_q == LAST_ROW) ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
      if (!primed) beat_d = beat_q + BW'(1);
    end
  end

  // The E neighbour lies three columns ahead of the centre, three lines back.
  always_comb begin
    col_p3_wide = {1'b0, col_q} + (CW + 1)'(3);
    if (col_p3_wide >= (CW + 1)'(WIDTH)) col_p3_wide = col_p3_wide - (CW + 1)'(WIDTH);
    col_p3 = col_p3_wide[CW-1:0];
  end

  always_comb begin
    px_e = line_q[2][col_p3];
    px_n = line_q[5][col_q];
    px_s = din;
    px_c = tap_q[2];
    px_w = tap_q[5];
    tap_d[0] = px_e;
    for (int i = 1; i < 6; i++) tap_d[i] = tap_q[i-1];
  end

  always_comb begin
    c_row  = (row_q >= RW'(3)) ? row_q - RW'(3) : row_q + RW'(HEIGHT - 3);
    border = (c_row < RW'(3)) || (c_row >= RW'(HEIGHT - 3)) ||
             (col_q < CW'(3)) || (col_q >= CW'(WIDTH - 3));
  end

  // 9-bit compares so that c+T and p+T never wrap near the rails.
  always_comb begin
    nb[0]    = px_n;
    nb[1]    = px_s;
    nb[2]    = px_e;
    nb[3]    = px_w;
    n_bright = '0;
    n_dark   = '0;
    for (int i = 0; i < 4; i++) begin
      if ({1'b0, nb[i]} > ({1'b0, px_c} + THR)) n_bright = n_bright + 3'd1;
      if (({1'b0, nb[i]} + THR) < {1'b0, px_c}) n_dark = n_dark + 3'd1;
    end
    corner = !border && ((n_bright >= 3'd3) || (n_dark >= 3'd3));
  end

  always_comb begin
    dout_d     = dout_q;
    validout_d = 1'b0;
    if (valid && primed) begin
      validout_d = 1'b1;
      dout_d     = corner ? 8'hFF : px_c;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      col_q      <= '0;
      row_q      <= '0;
      beat_q     <= '0;
      dout_q     <= '0;
      validout_q <= 1'b0;
    end else begin
      col_q      <= col_d;
      row_q      <= row_d;
      beat_q     <= beat_d;
      dout_q     <= dout_d;
      validout_q <= validout_d;
    end
  end

  // Pixel storage carries no reset; stale contents are masked by priming.
  always_ff @(posedge clock) begin
    if (valid && !reset) begin
      line_q[0][col_q] <= din;
      for (int i = 1; i < 6; i++) line_q[i][col_q] <= line_q[i-1][col_q];
      for (int i = 0; i < 6; i++) tap_q[i] <= tap_d[i];
    end
  end

  assign dout     = dout_q;
  assign validout = validout_q;

endmodule

// File: tb/tb_check4_detector.sv
// Bench for check4_detector: directed pattern frames plus random frames with
// idle gaps, checked beat by beat against a whole-frame reference model.
module tb_check4_detector;

  localparam int W = 16;
  localparam int H = 16;
  localparam int T = 20;
  localparam int FR = W * H;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] din;
  logic       valid;
  logic [7:0] dout;
  logic       validout;

  always #5 clock = ~clock;

  check4_detector #(.WIDTH(W), .HEIGHT(H), .THRESHOLD(T)) dut (
    .clock    (clock),
    .reset    (reset),
    .din      (din),
    .valid    (valid),
    .dout     (dout),
    .validout (validout)
  );

  logic [7:0] pix[$];
  logic [7:0] exp_q[$];
  logic [7:0] out_log[int];
  logic [7:0] frame [FR];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_bad++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp_v);
    end
  endtask

  // Reference: centre j in stream order since reset; neighbours by offset.
  function automatic logic [7:0] ref_pixel(input int j);
    int col, row, c, nbr, ndk;
    int nb [4];
    col = j % W;
    row = (j / W) % H;
    if (row < 3 || row >= H - 3 || col < 3 || col >= W - 3) return pix[j];
    c     = int'(pix[j]);
    nb[0] = int'(pix[j - 3 * W]);
    nb[1] = int'(pix[j + 3 * W]);
    nb[2] = int'(pix[j + 3]);
    nb[3] = int'(pix[j - 3]);
    nbr = 0;
    ndk = 0;
    for (int i = 0; i < 4; i++) begin
      if (nb[i] > c + T) nbr++;
      if (nb[i] + T < c) ndk++;
    end
    return (nbr >= 3 || ndk >= 3) ? 8'hFF : pix[j];
  endfunction

  task automatic beat(input logic v, input logic [7:0] px);
    logic exp_valid;
    int j;
    valid = v;
    din   = px;
    @(posedge clock);
    #1;
    exp_valid = 1'b0;
    j = -1;
    if (v) begin
      pix.push_back(px);
      if (pix.size() > 3 * W) begin
        j = pix.size() - 1 - 3 * W;
        exp_q.push_back(ref_pixel(j));
        exp_valid = 1'b1;
      end
    end
    chk1("validout", validout, exp_valid);
    if (exp_valid && validout) begin
      chk8("dout", dout, exp_q.pop_front());
      out_log[j] = dout;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    valid = 1'b1;
    din   = 8'($urandom_range(0, 255));
    @(posedge clock);
    #1;
    chk1("rst_validout", validout, 1'b0);
    chk8("rst_dout", dout, 8'h00);
    reset = 1'b0;
    valid = 1'b0;
    pix.delete();
    exp_q.delete();
    out_log.delete();
  endtask

  task automatic fill(input logic [7:0] v);
    for (int i = 0; i < FR; i++) frame[i] = v;
  endtask

  task automatic set_px(input int r, input int c, input logic [7:0] v);
    frame[r * W + c] = v;
  endtask

  task automatic fill_random();
    for (int i = 0; i < FR; i++) frame[i] = 8'($urandom_range(0, 255));
  endtask

  task automatic send_frame(input bit gaps);
    for (int i = 0; i < FR; i++) begin
      if (gaps) while ($urandom_range(0, 3) == 0) beat(1'b0, 8'($urandom_range(0, 255)));
      beat(1'b1, frame[i]);
    end
  endtask

  function automatic int fidx(input int f, input int r, input int c);
    return f * FR + r * W + c;
  endfunction

  initial begin
    reset = 1'b1;
    valid = 1'b0;
    din   = 8'h00;
    do_reset();
    do_reset();

    // f0: flat frame
    fill(8'd100);
    send_frame(1'b0);
    // f1: N, S, E bright around (8,8)
    fill(8'd100);
    set_px(5, 8, 8'd200); set_px(11, 8, 8'd200); set_px(8, 11, 8'd200);
    send_frame(1'b0);
    // f2: only N and S bright
    fill(8'd100);
    set_px(5, 8, 8'd200); set_px(11, 8, 8'd200);
    send_frame(1'b0);
    // f3: all four dark
    fill(8'd150);
    set_px(8, 8, 8'd200);
    set_px(5, 8, 8'd100); set_px(11, 8, 8'd100); set_px(8, 11, 8'd100); set_px(8, 5, 8'd100);
    send_frame(1'b0);
    // f4: neighbours at exactly c-T
    fill(8'd150);
    set_px(8, 8, 8'd200);
    set_px(5, 8, 8'd180); set_px(11, 8, 8'd180); set_px(8, 11, 8'd180); set_px(8, 5, 8'd180);
    send_frame(1'b0);
    // f5: strong patterns around border centres (1,5) and (8,14)
    fill(8'd100);
    set_px(4, 5, 8'd200); set_px(1, 8, 8'd200); set_px(1, 2, 8'd200);
    set_px(5, 14, 8'd200); set_px(11, 14, 8'd200); set_px(8, 11, 8'd200); set_px(9, 1, 8'd200);
    send_frame(1'b0);
    // f6, f7: random content with idle gaps
    fill_random();
    send_frame(1'b1);
    fill_random();
    send_frame(1'b1);

    chk8("flat_8_8", out_log[fidx(0, 8, 8)], 8'd100);
    chk8("bright3_8_8", out_log[fidx(1, 8, 8)], 8'hFF);
    chk8("bright2_8_8", out_log[fidx(2, 8, 8)], 8'd100);
    chk8("dark4_8_8", out_log[fidx(3, 8, 8)], 8'hFF);
    chk8("dark_eq_8_8", out_log[fidx(4, 8, 8)], 8'd200);
    chk8("border_1_5", out_log[fidx(5, 1, 5)], 8'd100);
    chk8("border_8_14", out_log[fidx(5, 8, 14)], 8'd100);

    // Reset mid-frame, then restream
    for (int i = 0; i < 100; i++) beat(1'b1, 8'($urandom_range(0, 255)));
    do_reset();
    fill_random();
    send_frame(1'b1);
    fill(8'd100);
    set_px(5, 8, 8'd200); set_px(11, 8, 8'd200); set_px(8, 5, 8'd200);
    send_frame(1'b0);
    fill_random();
    send_frame(1'b0);
    chk8("post_reset_corner", out_log[fidx(1, 8, 8)], 8'hFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
